// File: rtl/branch_predict_unit_if.sv
// Pipeline-side bundle for branch_predict_unit: IF lookup, EX resolve inputs and hazard outputs.
// Perf counter signals exist only when BRANCH_PERF_CNT_EN is defined.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_stall;
  logic [1:0]      pc_sel;
  logic [2:0]      branch_op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic            is_branch;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_stall, pc_sel, branch_op, data1, data2,
           ex_pc, ex_target, ex_pred_taken,
    input  if_pred_taken, is_branch, mispredict, redirect_pc,
           perf_branches, perf_mispredicts
  );
  modport slave (
    input  if_pc, ex_valid, ex_stall, pc_sel, branch_op, data1, data2,
           ex_pc, ex_target, ex_pred_taken,
    output if_pred_taken, is_branch, mispredict, redirect_pc,
           perf_branches, perf_mispredicts
  );
`else
  modport master (
    output if_pc, ex_valid, ex_stall, pc_sel, branch_op, data1, data2,
           ex_pc, ex_target, ex_pred_taken,
    input  if_pred_taken, is_branch, mispredict, redirect_pc
  );
  modport slave (
    input  if_pc, ex_valid, ex_stall, pc_sel, branch_op, data1, data2,
           ex_pc, ex_target, ex_pred_taken,
    output if_pred_taken, is_branch, mispredict, redirect_pc
  );
`endif
endinterface

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver with a PC-indexed saturating-counter BHT; mispredict/redirect are combinational.
// Optional perf counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2
) (
  input logic                clk,
  input logic                rst,
  branch_predict_unit_if.slave bp
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic [CNT_BITS-1:0] bht_q [BHT_ENTRIES];
  logic [CNT_BITS-1:0] cnt_d;
  logic [IDX_W-1:0]    if_idx;
  logic [IDX_W-1:0]    ex_idx;
  logic                cmp_taken;
  logic                taken;
  logic                train;
  logic                unused_if_pc;

  assign if_idx = bp.if_pc[IDX_W+1:2];
  assign ex_idx = bp.ex_pc[IDX_W+1:2];
  assign unused_if_pc = ^{bp.if_pc[XLEN-1:IDX_W+2], bp.if_pc[1:0]};

  always_comb begin
    cmp_taken = 1'b0;
    case (bp.branch_op)
      3'b000:  cmp_taken = (bp.data1 == bp.data2);
      3'b001:  cmp_taken = (bp.data1 != bp.data2);
      3'b100:  cmp_taken = ($signed(bp.data1) <  $signed(bp.data2));
      3'b101:  cmp_taken = ($signed(bp.data1) >= $signed(bp.data2));
      3'b110:  cmp_taken = (bp.data1 <  bp.data2);
      3'b111:  cmp_taken = (bp.data1 >= bp.data2);
      default: cmp_taken = 1'b0;
    endcase
  end

  assign taken = bp.ex_valid & ((bp.pc_sel == 2'b10) | ((bp.pc_sel == 2'b01) & cmp_taken));
  assign train = bp.ex_valid & ~bp.ex_stall & (bp.pc_sel == 2'b01);

  assign bp.is_branch     = taken;
  assign bp.mispredict    = bp.ex_valid & ~bp.ex_stall & (taken != bp.ex_pred_taken);
  assign bp.redirect_pc   = taken ? bp.ex_target : bp.ex_pc + XLEN'(4);
  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign bp.if_pred_taken = bht_q[if_idx][CNT_BITS-1];

  always_comb begin
    cnt_d = bht_q[ex_idx];
    if (taken) begin
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_BITS'(1);
    end else begin
      if (cnt_d != '0) cnt_d = cnt_d - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
    end else if (train) begin
      bht_q[ex_idx] <= cnt_d;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mp_q, perf_mp_d;
  logic        jump_evt;

  assign jump_evt  = bp.ex_valid & ~bp.ex_stall & (bp.pc_sel == 2'b10);
  assign perf_br_d = perf_br_q + 32'(train | jump_evt);
  assign perf_mp_d = perf_mp_q + 32'(bp.mispredict);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign bp.perf_branches    = perf_br_q;
  assign bp.perf_mispredicts = perf_mp_q;
`endif
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch comparator.
- Resolves conditional branches and jumps in EX, compares the outcome with the fetch-time prediction, and raises a flush/redirect on mismatch.
- Owns a PC-indexed branch history table (BHT) of saturating counters, trained on every resolved conditional branch.
- Sits between IF (lookup port), EX (resolve port) and the hazard unit (flush/stall).

Parameters:
- XLEN, 32, data and PC width.
- BHT_ENTRIES, 64, number of BHT counters; power of two, 2..1024.
- CNT_BITS, 2, saturating counter width, 1..4; predict taken when MSB is 1.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_pc  in  XLEN  fetch PC for lookup
- if_pred_taken  out  1  prediction for if_pc, carried down the pipe with the instruction
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_stall  in  1  EX frozen this cycle; no training, no perf counting
- pc_sel  in  2  00 none, 01 conditional, 10 unconditional jump, 11 none
- branch_op  in  3  funct3 compare code
- data1  in  XLEN  rs1 value
- data2  in  XLEN  rs2 value
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  computed taken target
- ex_pred_taken  in  1  prediction originally made for the EX instruction
- is_branch  out  1  actual taken outcome
- mispredict  out  1  flush IF/ID and redirect fetch
- redirect_pc  out  XLEN  fetch address when mispredict=1

Behaviour:
- Index is pc[log2(BHT_ENTRIES)+1:2] for both lookup and training.
- Compare codes (signed unless stated):
  - 000 eq
  - 001 ne
  - 100 lt
  - 101 ge
  - 110 ltu
  - 111 geu
  - 010/011 never taken.
- is_branch:
  - pc_sel 10: 1
  - pc_sel 01: compare result
  - pc_sel 00/11: 0
  - forced 0 when ex_valid=0.
- mispredict = ex_valid & ~ex_stall & (is_branch != ex_pred_taken). Combinational, zero latency.
- redirect_pc = is_branch ? ex_target : ex_pc+4, with +4 wrapping modulo 2^XLEN. Valid only while mispredict=1; otherwise it still follows the formula.
- if_pred_taken is combinational: MSB of BHT[index(if_pc)], read from the registered table.
- Training occurs at the rising edge when ex_valid & ~ex_stall & pc_sel==01:
  - taken: counter increments, saturating at 2^CNT_BITS-1.
  - not taken: counter decrements, saturating at 0.
- Jumps and non-branches never train the BHT.
- Same-index lookup and training in one cycle: the lookup returns the pre-update value (no bypass).
- A mispredict on a non-branch (ex_pred_taken=1, pc_sel 00) redirects to ex_pc+4 and does not train.
- Reset:
  - every counter goes to the weakly-not-taken value 2^(CNT_BITS-1)-1; with CNT_BITS=1 this is 0.
  - combinational outputs follow their inputs against the reset table.
- Reset asserted mid-operation clears the table immediately (asynchronously). No partial update survives.
- Stall: the table holds, outputs remain combinational, mispredict is suppressed.

Optional Feature:
- Macro BRANCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_branches[31:0] and perf_mispredicts[31:0].
  - Both reset to 0.
  - perf_branches increments on each qualifying training event and each valid unstalled jump.
  - perf_mispredicts increments on each cycle mispredict=1.
  - Both counters wrap 0xFFFFFFFF to 0.
- Undefined: the ports and registers are absent. All other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0. All entries read 01 (CNT_BITS=2).
- Three valid beq at ex_pc=0x100 with data1=data2=5 and ex_pred_taken=0:
  - first cycle: mispredict=1, redirect_pc=ex_target.
  - counter goes 01→10→11→11 (saturates).
  - if_pc=0x100 then predicts 1.
- blt with data1=-1, data2=1 -> taken. Same values on bltu -> not taken, redirect_pc=ex_pc+4. Codes 010/011 -> never taken.
- Jump (pc_sel 10) with ex_pred_taken=0 -> mispredict=1, redirect=ex_target, BHT unchanged. Same jump with ex_stall=1 -> mispredict=0.
- Lookup and training on the same index in the same cycle -> old prediction returned. Next cycle shows the updated value. ex_pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0.
- Assert rst asynchronously between edges after training -> table back to 01 before the next edge. With BRANCH_PERF_CNT_EN, both perf counters read 0.
